// File: rtl/icache_pf_engine.sv
`default_nettype none
// ============================================================================
// icache_pf_engine : line-by-line icache prefetch sequencer with bounded
//                    outstanding refills and a one-cycle completion pulse
// Revision 1.0
// ============================================================================
module icache_pf_engine #(
  parameter int LINE_BYTES      = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pf_req_i,
  input  logic [31:0] pf_addr_i,
  input  logic [7:0]  pf_size_i,
  output logic        pf_ack_o,
  output logic        pf_done_o,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        refill_req_o,
  output logic [31:0] refill_addr_o,
  input  logic        refill_gnt_i,
  input  logic        refill_r_valid_i
);

  localparam int              OS_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0]     LINE_INC  = 32'(LINE_BYTES);
  localparam logic [31:0]     LINE_MASK = ~(LINE_INC - 32'd1);
  localparam logic [OS_W-1:0] OS_MAX    = OS_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     cur_addr_q, cur_addr_d;
  logic [7:0]      remaining_q, remaining_d;
  logic [OS_W-1:0] outstanding_q, outstanding_d;
  logic            issue_fire;
  logic            resp_take;

  assign pf_ack_o      = (state_q == IDLE) & pf_req_i;
  assign refill_req_o  = (state_q == ISSUE) & (outstanding_q < OS_MAX) & ~abort_i;
  assign refill_addr_o = cur_addr_q;
  assign pf_done_o     = (state_q == DONE);
  assign busy_o        = (state_q != IDLE);

  assign issue_fire = refill_req_o & refill_gnt_i;
  // A response with nothing in flight is stale (e.g. from before a reset).
  assign resp_take  = refill_r_valid_i & (outstanding_q != '0);

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    outstanding_d = outstanding_q;

    case (state_q)
      IDLE: begin
        if (pf_req_i) begin
          cur_addr_d  = pf_addr_i & LINE_MASK;
          remaining_d = pf_size_i;
          state_d     = (pf_size_i == 8'd0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (issue_fire) begin
          cur_addr_d  = cur_addr_q + LINE_INC;
          remaining_d = remaining_q - 8'd1;
        end
        if ((issue_fire && (remaining_q == 8'd1)) || abort_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (outstanding_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case ({issue_fire, resp_take})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cur_addr_q    <= 32'd0;
      remaining_q   <= 8'd0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_pf_engine.sv
`default_nettype none
// Directed bench for icache_pf_engine: inputs change 1ns after posedge,
// outputs are observed on the falling edge.
module tb_icache_pf_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pf_req;
  logic [31:0] pf_addr;
  logic [7:0]  pf_size;
  logic        pf_ack;
  logic        pf_done;
  logic        abort;
  logic        busy;
  logic        refill_req;
  logic [31:0] refill_addr;
  logic        gnt;
  logic        r_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icache_pf_engine #(
    .LINE_BYTES      (16),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .pf_req_i         (pf_req),
    .pf_addr_i        (pf_addr),
    .pf_size_i        (pf_size),
    .pf_ack_o         (pf_ack),
    .pf_done_o        (pf_done),
    .abort_i          (abort),
    .busy_o           (busy),
    .refill_req_o     (refill_req),
    .refill_addr_o    (refill_addr),
    .refill_gnt_i     (gnt),
    .refill_r_valid_i (r_valid)
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; pf_req = 1'b0; pf_addr = 32'h0; pf_size = 8'h0;
    abort = 1'b0; gnt = 1'b0; r_valid = 1'b0;
    #2;
    checks++; if (pf_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", pf_ack); end
    checks++; if (pf_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", pf_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (refill_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", refill_req); end
    checks++; if (refill_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", refill_addr); end
    next_cycle;
    next_cycle;
    rst_n = 1'b1;
    sample;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b exp 0", busy); end
  endtask

  task automatic test_basic;
    logic g [0:31];
    int grants, dones, done_cyc, bad_addr;
    logic [31:0] exp_addr;
    for (int i = 0; i < 32; i++) g[i] = 1'b0;
    grants = 0; dones = 0; done_cyc = -1; bad_addr = 0;
    next_cycle;
    pf_addr = 32'h1C00_0004; pf_size = 8'd3; pf_req = 1'b1; gnt = 1'b1; r_valid = 1'b0;
    sample;
    checks++; if (pf_ack !== 1'b1) begin errors++; $display("FAIL basic_ack got %b exp 1", pf_ack); end
    checks++; if (refill_req !== 1'b0) begin errors++; $display("FAIL basic_req_at_T got %b exp 0", refill_req); end
    for (int c = 1; c <= 12; c++) begin
      next_cycle;
      pf_req  = 1'b0;
      r_valid = (c >= 2) ? g[c-2] : 1'b0;
      sample;
      g[c] = refill_req & gnt;
      if (g[c]) begin
        exp_addr = 32'h1C00_0000 + 32'(grants) * 32'h10;
        if (refill_addr !== exp_addr || c != grants + 1) bad_addr++;
        grants++;
      end
      if (pf_done === 1'b1) begin dones++; done_cyc = c; end
    end
    r_valid = 1'b0;
    checks++; if (bad_addr != 0) begin errors++; $display("FAIL basic_addr_seq got %0d bad grants exp 0", bad_addr); end
    checks++; if (grants != 3) begin errors++; $display("FAIL basic_grants got %0d exp 3", grants); end
    checks++; if (dones != 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", dones); end
    checks++; if (done_cyc != 7) begin errors++; $display("FAIL basic_done_cycle got %0d exp 7", done_cyc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_backpressure;
    int grants, early_grants, req_while_full, dones, done_cyc, given, bad_addr;
    grants = 0; early_grants = 0; req_while_full = 0; dones = 0; done_cyc = -1;
    given = 0; bad_addr = 0;
    next_cycle;
    pf_addr = 32'h2000_0000; pf_size = 8'd8; pf_req = 1'b1; gnt = 1'b1; r_valid = 1'b0;
    sample;
    for (int c = 1; c <= 25; c++) begin
      next_cycle;
      pf_req  = 1'b0;
      r_valid = (c >= 9 && given < 8);
      if (r_valid) given++;
      sample;
      if (refill_req && gnt) begin
        if (refill_addr !== 32'h2000_0000 + 32'(grants) * 32'h10) bad_addr++;
        grants++;
        if (c <= 8) early_grants++;
      end
      if (c >= 5 && c <= 9 && refill_req) req_while_full++;
      if (pf_done === 1'b1) begin dones++; done_cyc = c; end
    end
    r_valid = 1'b0;
    checks++; if (early_grants != 4) begin errors++; $display("FAIL bp_grants_before_release got %0d exp 4", early_grants); end
    checks++; if (req_while_full != 0) begin errors++; $display("FAIL bp_req_while_full got %0d exp 0", req_while_full); end
    checks++; if (grants != 8) begin errors++; $display("FAIL bp_total_grants got %0d exp 8", grants); end
    checks++; if (bad_addr != 0) begin errors++; $display("FAIL bp_addr_seq got %0d bad exp 0", bad_addr); end
    checks++; if (done_cyc != 18 || dones != 1) begin errors++; $display("FAIL bp_done got cycle %0d count %0d exp cycle 18 count 1", done_cyc, dones); end
  endtask

  task automatic test_size0;
    next_cycle;
    pf_addr = 32'h0000_1234; pf_size = 8'd0; pf_req = 1'b1; gnt = 1'b1; r_valid = 1'b0;
    sample;
    checks++; if (pf_ack !== 1'b1) begin errors++; $display("FAIL size0_ack got %b exp 1", pf_ack); end
    next_cycle;
    pf_req = 1'b0;
    sample;
    checks++; if (pf_done !== 1'b1) begin errors++; $display("FAIL size0_done got %b exp 1", pf_done); end
    checks++; if (refill_req !== 1'b0) begin errors++; $display("FAIL size0_req got %b exp 0", refill_req); end
    next_cycle;
    sample;
    checks++; if (pf_done !== 1'b0 || busy !== 1'b0 || refill_req !== 1'b0) begin
      errors++; $display("FAIL size0_idle got done %b busy %b req %b exp 0 0 0", pf_done, busy, refill_req);
    end
  endtask

  task automatic test_wrap;
    logic g [0:31];
    logic [31:0] exp_a [0:2];
    int grants, bad_addr, done_cyc;
    exp_a[0] = 32'hFFFF_FFE0; exp_a[1] = 32'hFFFF_FFF0; exp_a[2] = 32'h0000_0000;
    for (int i = 0; i < 32; i++) g[i] = 1'b0;
    grants = 0; bad_addr = 0; done_cyc = -1;
    next_cycle;
    pf_addr = 32'hFFFF_FFE8; pf_size = 8'd3; pf_req = 1'b1; gnt = 1'b1; r_valid = 1'b0;
    sample;
    for (int c = 1; c <= 10; c++) begin
      next_cycle;
      pf_req  = 1'b0;
      r_valid = g[c-1];
      sample;
      g[c] = refill_req & gnt;
      if (g[c]) begin
        if (grants > 2 || refill_addr !== exp_a[grants]) bad_addr++;
        grants++;
      end
      if (pf_done === 1'b1) done_cyc = c;
    end
    r_valid = 1'b0;
    checks++; if (bad_addr != 0 || grants != 3) begin errors++; $display("FAIL wrap_addrs got %0d bad of %0d grants exp 0 of 3", bad_addr, grants); end
    checks++; if (done_cyc != 6) begin errors++; $display("FAIL wrap_done_cycle got %0d exp 6", done_cyc); end
  endtask

  task automatic test_abort;
    int grants, late_req, dones, done_cyc;
    grants = 0; late_req = 0; dones = 0; done_cyc = -1;
    next_cycle;
    pf_addr = 32'h3000_0000; pf_size = 8'd10; pf_req = 1'b1; gnt = 1'b1; r_valid = 1'b0; abort = 1'b0;
    sample;
    for (int c = 1; c <= 14; c++) begin
      next_cycle;
      pf_req  = 1'b0;
      abort   = (c >= 4);
      r_valid = (c == 3 || c == 6 || c == 8);
      sample;
      if (refill_req && gnt) grants++;
      if (c >= 4 && refill_req) late_req++;
      if (pf_done === 1'b1) begin dones++; done_cyc = c; end
    end
    r_valid = 1'b0; abort = 1'b0;
    checks++; if (grants != 3) begin errors++; $display("FAIL abort_grants got %0d exp 3", grants); end
    checks++; if (late_req != 0) begin errors++; $display("FAIL abort_req_after got %0d exp 0", late_req); end
    checks++; if (done_cyc != 10 || dones != 1) begin errors++; $display("FAIL abort_done got cycle %0d count %0d exp cycle 10 count 1", done_cyc, dones); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_stall_reset;
    int unstable, grants, done_cyc;
    unstable = 0; grants = 0; done_cyc = -1;
    next_cycle;
    pf_addr = 32'h4000_0058; pf_size = 8'd4; pf_req = 1'b1; gnt = 1'b0; r_valid = 1'b0;
    sample;
    checks++; if (pf_ack !== 1'b1) begin errors++; $display("FAIL stall_ack got %b exp 1", pf_ack); end
    for (int c = 1; c <= 5; c++) begin
      next_cycle;
      pf_req = 1'b0;
      sample;
      if (refill_req !== 1'b1 || refill_addr !== 32'h4000_0050) unstable++;
    end
    checks++; if (unstable != 0) begin errors++; $display("FAIL stall_hold got %0d unstable cycles exp 0", unstable); end
    next_cycle;
    rst_n = 1'b0; r_valid = 1'b1;
    #1;
    checks++; if (refill_req !== 1'b0 || refill_addr !== 32'h0) begin
      errors++; $display("FAIL midreset_refill got req %b addr %h exp 0 0", refill_req, refill_addr);
    end
    checks++; if (busy !== 1'b0 || pf_done !== 1'b0 || pf_ack !== 1'b0) begin
      errors++; $display("FAIL midreset_status got busy %b done %b ack %b exp 0 0 0", busy, pf_done, pf_ack);
    end
    next_cycle;
    next_cycle;
    rst_n = 1'b1;
    next_cycle;
    r_valid = 1'b0;
    pf_addr = 32'h5000_0000; pf_size = 8'd1; pf_req = 1'b1; gnt = 1'b1;
    sample;
    checks++; if (pf_ack !== 1'b1) begin errors++; $display("FAIL postreset_ack got %b exp 1", pf_ack); end
    for (int c = 1; c <= 8; c++) begin
      next_cycle;
      pf_req  = 1'b0;
      r_valid = (c == 3);
      sample;
      if (refill_req && gnt) begin
        grants++;
        if (refill_addr !== 32'h5000_0000) unstable++;
      end
      if (pf_done === 1'b1) done_cyc = c;
    end
    r_valid = 1'b0;
    checks++; if (grants != 1 || unstable != 0) begin errors++; $display("FAIL postreset_grant got %0d grants %0d bad exp 1 0", grants, unstable); end
    checks++; if (done_cyc != 5) begin errors++; $display("FAIL postreset_done_cycle got %0d exp 5", done_cyc); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_size0;
    test_wrap;
    test_abort;
    test_stall_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache_pf_engine.md
# icache_pf_engine

Prefetch sequencer sitting directly downstream of the shared instruction-cache control unit. It accepts a prefetch command (start address, length in cache lines) over the `pf_req`/`pf_ack` handshake, issues one refill request per cache line to the icache refill port with bounded outstanding transactions, and reports completion on `pf_done`. The control unit forwards `pf_done` as the cluster prefetch event.

## Interface
Parameters:
- `LINE_BYTES`, 16: cache line size in bytes; power of two, ≥4.
- `MAX_OUTSTANDING`, 4: maximum number of refill requests granted but not yet returned; range 1..15.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `pf_req_i`  in  1  prefetch command request; held high until `pf_ack_o`.
- `pf_addr_i`  in  32  prefetch start byte address.
- `pf_size_i`  in  8  number of lines to prefetch.
- `pf_ack_o`  out  1  command accepted; combinational.
- `pf_done_o`  out  1  one-cycle pulse when a command completes.
- `abort_i`  in  1  stop issuing new lines; level-sensitive.
- `busy_o`  out  1  high in any state other than IDLE.
- `refill_req_o`  out  1  refill request valid.
- `refill_addr_o`  out  32  line-aligned refill address.
- `refill_gnt_i`  in  1  refill request accepted this cycle.
- `refill_r_valid_i`  in  1  one refill response returned this cycle.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: `pf_ack_o = pf_req_i`.
  - On `pf_req_i`, latch `cur_addr = pf_addr_i & ~(LINE_BYTES-1)` and `remaining = pf_size_i`.
  - If `pf_size_i == 0`, go to DONE; otherwise go to ISSUE.
  - `pf_ack_o` is 0 in every other state.
- ISSUE: `refill_req_o = (outstanding < MAX_OUTSTANDING) & ~abort_i`, with `refill_addr_o = cur_addr`.
  - On `refill_req_o & refill_gnt_i`: `cur_addr += LINE_BYTES` (mod 2^32; the address wraps from 0xFFFF_FFF0 to 0x0 with no fault), `remaining -= 1`, `outstanding += 1`.
  - When the last line is granted (remaining goes 1→0), or when `abort_i` is high, go to DRAIN.
  - `refill_req_o` must not drop before grant unless `abort_i` rises; `refill_addr_o` is stable while the request is pending.
- DRAIN: no requests. When `outstanding == 0`, go to DONE.
- DONE: `pf_done_o = 1` for exactly one cycle, then go to IDLE.
- Outstanding counter:
  - Width `$clog2(MAX_OUTSTANDING+1)`.
  - Increments on grant and decrements on `refill_r_valid_i`; both in the same cycle leave it unchanged.
  - `refill_r_valid_i` with `outstanding == 0` is ignored (no underflow).
  - The counter is shared across states, so responses arriving in DRAIN are counted.
- Abort: `abort_i` in IDLE has no effect; a command is still accepted. An aborted command still ends with one `pf_done_o` pulse after drain.
- A command is accepted only in IDLE. `pf_req_i` during a busy state waits.

## Timing
- Reset values: state IDLE; `pf_ack_o`=0, `pf_done_o`=0, `busy_o`=0, `refill_req_o`=0, `refill_addr_o`=0; counters 0.
- Acceptance cycle T (IDLE, `pf_req_i`=1): `pf_ack_o`=1 in cycle T. The first `refill_req_o` appears in T+1.
- With `refill_gnt_i` tied high and no back-pressure, one line is issued per cycle.
- N lines issue in cycles T+1..T+N.
- `pf_done_o` fires 2 cycles after the cycle in which the last response is received:
  - cycle 1: counter reaches 0, state still DRAIN;
  - cycle 2: DONE.
- Size 0: `pf_done_o` in T+1, back to IDLE in T+2.
- The earliest next acceptance is the cycle after DONE.
- Reset mid-operation: return to IDLE immediately. Responses returned after reset are ignored because the counter is 0.

## Test plan
- Basic: addr 0x1C00_0004, size 3, gnt=1, each response 2 cycles after its grant.
  - Expect refill addresses 0x1C00_0000, 0x1C00_0010, 0x1C00_0020 in consecutive cycles.
  - Expect exactly one `pf_done_o` pulse, then `busy_o`=0.
- Back-pressure: MAX_OUTSTANDING=4, size 8, gnt=1, responses withheld.
  - Expect exactly 4 grants, then `refill_req_o`=0.
  - Release one response per cycle; expect issue to resume 1:1 and `pf_done_o` only after the 8th response.
- Size 0: `pf_req_i` with size 0.
  - Expect `pf_ack_o` the same cycle, `pf_done_o` the next cycle, and no refill requests.
- Wrap: addr 0xFFFF_FFE8, size 3.
  - Expect addresses 0xFFFF_FFE0, 0xFFFF_FFF0, 0x0000_0000.
- Abort: size 10; assert `abort_i` after 3 grants with 2 responses pending.
  - Expect no further requests, done after the 3rd response, and 3 total grants.
- Stall and reset: hold gnt=0 for 5 cycles.
  - Expect `refill_req_o` and `refill_addr_o` stable throughout.
  - Assert `rst_ni`=0 mid-ISSUE; expect all outputs 0 immediately and a fresh command accepted after reset.
